modexp_ctrl: RTL and testbench

//  Sequencer for modular exponentiation result = base^exponent mod modulus (left-to-right square-and-multiply).

---
 rtl/modexp_pkg.sv | 31 +++
 rtl/modexp_if.sv | 23 ++
 rtl/modexp_mul_stage.sv | 19 +
 rtl/modexp_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/modexp_pkg.sv
// Shared types and reset constants for the modular-exponentiation sequencer.
package modexp_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_EXP_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RED_BASE,
        ST_SQ,
        ST_MUL,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } modexp_state_t;

    typedef enum logic [1:0] {
        OP_RED,
        OP_SQ,
        OP_MUL
    } modexp_op_t;

    localparam modexp_state_t STATE_RST = ST_IDLE;
    localparam modexp_op_t    OP_RST    = OP_RED;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modexp_if.sv
// Request/response bus between the sequencer and the external iterative modulus unit.
interface modexp_if
    import modexp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 mod_ready_out;
    logic [2*WIDTH-1:0]   mod_value_out;
    logic [WIDTH-1:0]     mod_modulus_out;
    logic [WIDTH-1:0]     mod_value_in;
    logic                 mod_busy_in;
    logic                 mod_valid_in;

    modport master (
        output mod_ready_out, mod_value_out, mod_modulus_out,
        input  mod_value_in, mod_busy_in, mod_valid_in
    );

    modport slave (
        input  mod_ready_out, mod_value_out, mod_modulus_out,
        output mod_value_in, mod_busy_in, mod_valid_in
    );
endinterface

// File: rtl/modexp_mul_stage.sv
// Registered unsigned WIDTHxWIDTH multiply, one cycle latency; output holds until the next load.
module modexp_mul_stage #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product
);
    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
        end else if (load) begin
            product <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end
    end
endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modulus unit.
// Define MODEXP_CONST_TIME_EN to issue a multiply for every exponent bit (constant op count).
//
// state    | meaning
// IDLE     | waiting for start_in
// LOAD     | screen modulus 0/1 and exponent 0, init acc and bit index
// RED_BASE | load base*1 into the multiplier for base reduction
// SQ       | load acc*acc into the multiplier
// MUL      | load acc*base_r into the multiplier
// REQ      | pulse mod_ready_out once the modulus unit is idle
// WAIT     | wait for mod_valid_in, capture remainder
// DONE     | publish result, pulse valid_out, drop busy_out
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [WIDTH-1:0]      base_in,
    input  logic [EXP_WIDTH-1:0]  exponent_in,
    input  logic [WIDTH-1:0]      modulus_in,
    output logic [WIDTH-1:0]      result_out,
    output logic                  busy_out,
    output logic                  valid_out,
    output logic                  error_out,
    modexp_if.master              mod_bus
);
    localparam int IDX_W = idx_width(EXP_WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    modexp_state_t          state, state_nxt;
    modexp_op_t             op_r, op_nxt;
    logic [WIDTH-1:0]       base_r, mod_r, acc;
    logic [EXP_WIDTH-1:0]   exp_r;
    logic [IDX_W-1:0]       idx;
    logic                   err_r;
    logic                   mul_load, mod_ready;
    logic [WIDTH-1:0]       mul_a, mul_b;
    logic [2*WIDTH-1:0]     product;
    logic                   bit_set, last_bit;

    assign bit_set  = exp_r[idx];
    assign last_bit = (idx == '0);

    modexp_mul_stage #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk_in),
        .rst     (rst_in),
        .load    (mul_load),
        .a       (mul_a),
        .b       (mul_b),
        .product (product)
    );

    assign mod_bus.mod_value_out   = product;
    assign mod_bus.mod_modulus_out = mod_r;
    assign mod_bus.mod_ready_out   = mod_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= STATE_RST;
            op_r  <= OP_RST;
        end else begin
            state <= state_nxt;
            op_r  <= op_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_r;
        mul_load  = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        mod_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_in) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (mod_r == '0 || mod_r == WIDTH'(1) || exp_r == '0) state_nxt = ST_DONE;
                else                                                 state_nxt = ST_RED_BASE;
            end
            ST_RED_BASE: begin
                mul_load  = 1'b1;
                mul_a     = base_r;
                mul_b     = WIDTH'(1);
                op_nxt    = OP_RED;
                state_nxt = ST_REQ;
            end
            ST_SQ: begin
                mul_load  = 1'b1;
                mul_a     = acc;
                mul_b     = acc;
                op_nxt    = OP_SQ;
                state_nxt = ST_REQ;
            end
            ST_MUL: begin
                mul_load  = 1'b1;
                mul_a     = acc;
                mul_b     = base_r;
                op_nxt    = OP_MUL;
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!mod_bus.mod_busy_in) begin
                    mod_ready = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mod_bus.mod_valid_in) begin
                    case (op_r)
                        OP_RED:  state_nxt = ST_SQ;
                        OP_SQ: begin
                            if (CONST_TIME || bit_set) state_nxt = ST_MUL;
                            else if (last_bit)         state_nxt = ST_DONE;
                            else                       state_nxt = ST_SQ;
                        end
                        default: state_nxt = last_bit ? ST_DONE : ST_SQ;
                    endcase
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            base_r     <= '0;
            mod_r      <= '0;
            exp_r      <= '0;
            acc        <= '0;
            idx        <= '0;
            err_r      <= 1'b0;
            result_out <= '0;
            busy_out   <= 1'b0;
            valid_out  <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        base_r   <= base_in;
                        exp_r    <= exponent_in;
                        mod_r    <= modulus_in;
                        err_r    <= 1'b0;
                        busy_out <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    idx <= IDX_TOP;
                    if (mod_r == '0) begin
                        acc   <= '0;
                        err_r <= 1'b1;
                    end else if (mod_r == WIDTH'(1)) begin
                        acc <= '0;
                    end else begin
                        acc <= WIDTH'(1);
                    end
                end
                ST_WAIT: begin
                    if (mod_bus.mod_valid_in) begin
                        case (op_r)
                            OP_RED: base_r <= mod_bus.mod_value_in;
                            OP_SQ: begin
                                acc <= mod_bus.mod_value_in;
                                if (!(CONST_TIME || bit_set)) idx <= idx - 1'b1;
                            end
                            default: begin
                                // constant-time mode discards the product for clear bits
                                if (bit_set) acc <= mod_bus.mod_value_in;
                                idx <= idx - 1'b1;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    result_out <= acc;
                    error_out  <= err_r;
                    valid_out  <= 1'b1;
                    busy_out   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural modulus unit plus right-to-left reference exponentiation.
module tb_modexp_ctrl;
    import modexp_pkg::*;

    localparam int W  = 16;
    localparam int EW = 16;
`ifdef MODEXP_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    base, modulus;
    logic [EW-1:0]   exponent;
    logic [W-1:0]    result;
    logic            busy, valid, error;

    int checks;
    int failures;

    modexp_if #(.WIDTH(W)) bus ();

    modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .base_in     (base),
        .exponent_in (exponent),
        .modulus_in  (modulus),
        .result_out  (result),
        .busy_out    (busy),
        .valid_out   (valid),
        .error_out   (error),
        .mod_bus     (bus)
    );

    always #5 clk = ~clk;

    // Modulus unit model: random latency, flags requests while busy or unstable dividends.
    logic            m_busy, m_valid, stray_valid;
    logic [W-1:0]    m_rem, held_mod;
    logic [2*W-1:0]  held_value;
    int              m_cnt;
    int              ready_cnt;
    int              proto_err;

    assign bus.mod_busy_in  = m_busy;
    assign bus.mod_valid_in = m_valid | stray_valid;
    assign bus.mod_value_in = m_rem;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_rem   <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy) begin
                if (bus.mod_ready_out) proto_err <= proto_err + 1;
                if (bus.mod_value_out !== held_value) proto_err <= proto_err + 1;
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b1;
                    m_rem   <= (held_mod == '0) ? '0 : W'(held_value % {{W{1'b0}}, held_mod});
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (bus.mod_ready_out) begin
                ready_cnt  <= ready_cnt + 1;
                held_value <= bus.mod_value_out;
                held_mod   <= bus.mod_modulus_out;
                m_busy     <= 1'b1;
                m_cnt      <= int'($urandom_range(0, 2));
            end
        end
    end

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [EW-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r, x, mm;
        logic [EW-1:0]   k;
        if (m == '0) return '0;
        mm = longint'(m);
        r  = 1 % mm;
        x  = longint'(b) % mm;
        k  = e;
        while (k != '0) begin
            if (k[0]) r = (r * x) % mm;
            x = (x * x) % mm;
            k = k >> 1;
        end
        return W'(r);
    endfunction

    function automatic int ref_ops(input logic [EW-1:0] e, input logic [W-1:0] m);
        if (m <= W'(1) || e == '0) return 0;
        return 1 + EW + (CONST_TIME ? EW : $countones(e));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m,
                          input bit poke_start);
        int           ops0, cyc;
        logic [W-1:0] exp_res;
        int           exp_ops;
        exp_res = ref_modexp(b, e, m);
        exp_ops = ref_ops(e, m);
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        ops0 = ready_cnt;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        cyc = 0;
        while (!valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (poke_start && cyc == 6) begin
                base = ~b; exponent = e ^ 16'h5a5a; modulus = m + 3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("valid_seen", 64'(valid), 64'(1));
        check("result", 64'(result), 64'(exp_res));
        check("error", 64'(error), 64'(m == '0));
        check("busy_at_valid", 64'(busy), 64'(0));
        check("op_count", 64'(ready_cnt - ops0), 64'(exp_ops));
        @(negedge clk);
        check("valid_single", 64'(valid), 64'(0));
        check("result_held", 64'(result), 64'(exp_res));
    endtask

    initial begin
        int           ops0, cyc;
        bit           saw_valid;
        logic [W-1:0] rb, rm;
        logic [EW-1:0] re;
        checks = 0; failures = 0; ready_cnt = 0; proto_err = 0;
        rst = 1'b1; start = 1'b0; stray_valid = 1'b0;
        base = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 64'(result), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_ready", 64'(bus.mod_ready_out), 64'(0));
        check("rst_value", 64'(bus.mod_value_out), 64'(0));
        check("rst_modulus", 64'(bus.mod_modulus_out), 64'(0));
        rst = 1'b0;

        run_op(16'd4, 16'd13, 16'd497, 1'b0);
        check("known_445", 64'(result), 64'(445));
        run_op(16'd100, 16'd3, 16'd7, 1'b0);
        run_op(16'd7, 16'd0, 16'd13, 1'b0);
        run_op(16'd7, 16'd0, 16'd1, 1'b0);
        run_op(16'd7, 16'd5, 16'd1, 1'b0);
        run_op(16'd7, 16'd5, 16'd0, 1'b0);
        run_op(16'd4, 16'd13, 16'd497, 1'b1);
        run_op(16'd9, 16'h8001, 16'd497, 1'b0);

        // stray valid while idle must not disturb anything
        @(negedge clk); stray_valid = 1'b1;
        @(negedge clk); stray_valid = 1'b0;
        check("stray_busy", 64'(busy), 64'(0));
        check("stray_valid_out", 64'(valid), 64'(0));
        check("stray_result", 64'(result), 64'(ref_modexp(16'd9, 16'h8001, 16'd497)));
        run_op(16'd4, 16'd13, 16'd497, 1'b0);

        // reset while waiting on the first square
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        ops0 = ready_cnt;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!((ready_cnt - ops0) == 2 && m_busy) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_sq_wait", 64'((ready_cnt - ops0) == 2 && m_busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_valid", 64'(valid), 64'(0));
        check("midrst_ready", 64'(bus.mod_ready_out), 64'(0));
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        check("midrst_no_valid", 64'(saw_valid), 64'(0));
        run_op(16'd4, 16'd13, 16'd497, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rb = W'($urandom);
            re = EW'($urandom);
            rm = (i % 4 == 0) ? W'($urandom_range(2, 20)) : W'($urandom_range(2, 65535));
            run_op(rb, re, rm, 1'b0);
        end

        check("protocol", 64'(proto_err), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
